seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 155 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver with a double-buffered display word,
// anti-ghosting blank slots, and optional leading-zero suppression.
module seg7_scan_driver #(
  parameter logic [15:0] REFRESH_DIV  = 16'd2500,
  parameter logic [7:0]  BLANK_CYCLES = 8'd50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dots_in,
  input  logic        lz_suppress,
  output logic [6:0]  seg_out,
  output logic        dot_out,
  output logic [3:0]  digit_sel,
  output logic        frame_start
);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  localparam logic [15:0] BLANK_LAST = {8'd0, BLANK_CYCLES} - 16'd1;
  localparam logic [15:0] ON_LAST    = REFRESH_DIV - 16'd1;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [0:0]  state_r;
  logic [15:0] cnt_r;
  logic [1:0]  idx_r;
  logic [15:0] pend_digits_r;
  logic [3:0]  pend_dots_r;
  logic        pend_valid_r;
  logic [15:0] disp_digits_r;
  logic [3:0]  disp_dots_r;

  logic        accept_s;
  logic        xfer_s;
  logic        frame_start_s;
  logic [3:0]  cur_code_s;
  logic [3:0]  zero_s;
  logic        lz_blank_s;

  assign in_ready = !pend_valid_r;
  assign accept_s = in_valid && !pend_valid_r;

  // Frame boundary is gated by rst_n so it stays low during reset without a clock.
  always_comb begin
    frame_start_s = rst_n && ena && (state_r == ST_BLANK) && (idx_r == 2'd0)
                    && (cnt_r == 16'd0);
    xfer_s        = frame_start_s && pend_valid_r;
  end

  // Scan FSM: BLANK then ON per digit, frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BLANK;
      cnt_r   <= 16'd0;
      idx_r   <= 2'd0;
    end else if (ena) begin
      case (state_r)
        ST_BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_r <= ST_ON;
            cnt_r   <= 16'd0;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_ON: begin
          if (cnt_r == ON_LAST) begin
            state_r <= ST_BLANK;
            cnt_r   <= 16'd0;
            idx_r   <= idx_r + 2'd1;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= ST_BLANK;
          cnt_r   <= 16'd0;
        end
      endcase
    end
  end

  // Pending buffer: accept when empty, drain at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_digits_r <= 16'd0;
      pend_dots_r   <= 4'd0;
      pend_valid_r  <= 1'b0;
    end else if (accept_s) begin
      pend_digits_r <= digits_in;
      pend_dots_r   <= dots_in;
      pend_valid_r  <= 1'b1;
    end else if (xfer_s) begin
      pend_valid_r <= 1'b0;
    end
  end

  // Display register only changes at a frame boundary, so a frame is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_digits_r <= 16'd0;
      disp_dots_r   <= 4'd0;
    end else if (xfer_s) begin
      disp_digits_r <= pend_digits_r;
      disp_dots_r   <= pend_dots_r;
    end
  end

  // Output mux: a digit is lead-zero blanked when it and every higher digit are zero.
  always_comb begin
    cur_code_s = disp_digits_r[{idx_r, 2'b00} +: 4];
    zero_s[0]  = (disp_digits_r[3:0]   == 4'd0);
    zero_s[1]  = (disp_digits_r[7:4]   == 4'd0);
    zero_s[2]  = (disp_digits_r[11:8]  == 4'd0);
    zero_s[3]  = (disp_digits_r[15:12] == 4'd0);
    case (idx_r)
      2'd3:    lz_blank_s = zero_s[3];
      2'd2:    lz_blank_s = zero_s[3] && zero_s[2];
      2'd1:    lz_blank_s = zero_s[3] && zero_s[2] && zero_s[1];
      default: lz_blank_s = 1'b0;
    endcase
    frame_start = frame_start_s;
    if (ena && (state_r == ST_ON)) begin
      digit_sel = 4'b0001 << idx_r;
      seg_out   = (lz_suppress && lz_blank_s) ? 7'h00 : seg_decode(cur_code_s);
      dot_out   = disp_dots_r[idx_r];
    end else begin
      digit_sel = 4'b0000;
      seg_out   = 7'h00;
      dot_out   = 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus queues expected ON-slot outputs,
// a negedge monitor pops and compares whenever a digit is lit.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] digits_in = 16'd0;
  logic [3:0]  dots_in = 4'd0;
  logic        lz_suppress = 1'b0;
  logic [6:0]  seg_out;
  logic        dot_out;
  logic [3:0]  digit_sel;
  logic        frame_start;

  int total = 0;
  int bad = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_v;

  seg7_scan_driver #(.REFRESH_DIV(16'd4), .BLANK_CYCLES(8'd2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .digits_in(digits_in), .dots_in(dots_in), .lz_suppress(lz_suppress),
    .seg_out(seg_out), .dot_out(dot_out), .digit_sel(digit_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_seg(input logic [15:0] d, input int idx, input logic lz);
    logic [15:0] up;
    up = d >> (4 * idx);
    if (lz && idx > 0 && up == 16'd0) return 7'h00;
    case (up[3:0])
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;  4'd3: return 7'h4F;
      4'd4: return 7'h66;  4'd5: return 7'h6D;  4'd6: return 7'h7D;  4'd7: return 7'h07;
      4'd8: return 7'h7F;  4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] d, input logic [3:0] dt, input logic lz, input int n);
    int k = 0;
    logic [3:0] oh;
    for (int idx = 0; idx < 4; idx++) begin
      oh = 4'b0001 << idx;
      for (int c = 0; c < 4; c++) begin
        if (k < n) exp_q.push_back({oh, model_seg(d, idx, lz), dt[idx]});
        k++;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 200);
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] dt, output int n);
    in_valid  = 1'b1;
    digits_in = d;
    dots_in   = dt;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: lit slots pop the scoreboard, dark slots must have no segments.
  always @(negedge clk) begin
    if (digit_sel != 4'd0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scan_unexpected: got %0h expected none", {digit_sel, seg_out, dot_out});
      end else begin
        exp_v = exp_q.pop_front();
        check("scan", {20'd0, digit_sel, seg_out, dot_out}, {20'd0, exp_v});
      end
    end else begin
      check("dark", {24'd0, seg_out, dot_out}, 32'd0);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    push_frame(16'h0000, 4'b0000, 1'b0, 16);  // F0: reset content
    push_frame(16'h1234, 4'b0001, 1'b0, 16);  // F1: A
    push_frame(16'h5678, 4'b1010, 1'b0, 16);  // F2: B
    push_frame(16'h0070, 4'b0100, 1'b1, 16);  // F3: C, lz
    push_frame(16'h0000, 4'b0000, 1'b1, 16);  // F4: D, lz
    push_frame(16'h123A, 4'b0001, 1'b0, 16);  // F5: E, illegal code
    push_frame(16'h123A, 4'b0001, 1'b0, 16);  // F6: E, ena gap
    push_frame(16'h9081, 4'b1000, 1'b0, 9);   // F7: cut by reset in digit 2
    push_frame(16'h0000, 4'b0000, 1'b0, 16);  // F8: pending discarded

    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_sel", digit_sel, 4'd0);
    check("rst_seg", seg_out, 7'd0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_fs", frame_start, 1'b0);
    rst_n = 1'b1;
    #1;
    check("first_fs", frame_start, 1'b1);

    send(16'h1234, 4'b0001, n);
    check("a_wait", n, 0);
    check("a_ready", in_ready, 1'b0);
    send(16'h5678, 4'b1010, n);
    check("b_wait", n, 24);
    check("b_ready", in_ready, 1'b0);
    wait_frame(n);
    check("f2_period", n, 22);

    tick();
    send(16'h0070, 4'b0100, n);
    wait_frame(n);
    check("f3_period", n, 22);
    lz_suppress = 1'b1;
    tick();
    send(16'h0000, 4'b0000, n);
    wait_frame(n);
    check("f4_period", n, 22);
    tick();
    send(16'h123A, 4'b0001, n);
    wait_frame(n);
    check("f5_period", n, 22);
    lz_suppress = 1'b0;
    wait_frame(n);
    check("f6_period", n, 24);

    repeat (10) tick();
    ena = 1'b0;
    in_valid = 1'b1;
    digits_in = 16'h9081;
    dots_in = 4'b1000;
    #1;
    check("ena_off_sel", digit_sel, 4'd0);
    tick();
    in_valid = 1'b0;
    check("ena_accept", in_ready, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("ena_frozen", {frame_start, digit_sel}, 5'd0);
    end
    ena = 1'b1;
    #1;
    check("ena_resume", digit_sel, 4'b0010);
    wait_frame(n);
    check("f7_remaining", n, 14);

    tick();
    send(16'h8888, 4'b1111, n);
    check("g_ready", in_ready, 1'b0);
    repeat (13) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_sel", digit_sel, 4'd0);
    check("midrst_seg", {seg_out, dot_out}, 8'd0);
    check("midrst_ready", in_ready, 1'b1);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("rerst_fs", frame_start, 1'b1);
    check("rerst_ready", in_ready, 1'b1);
    wait_frame(n);
    check("f8_period", n, 24);
    check("queue_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
